rp_8bit_pcint: RTL



---
 rtl/rp_8bit_pcint_pkg.sv | 20 ++
 rtl/rp_8bit_pcint_if.sv | 16 +
 rtl/rp_8bit_pcint_edge.sv | 57 +++++
 rtl/rp_8bit_pcint.sv | 109 ++++++++++
 4 files changed

// File: rtl/rp_8bit_pcint_pkg.sv
// Shared constants for the rp_8bit_pcint pin-change interrupt controller.
// Holds the register slot indices used by the one-hot I/O select lines, the
// bit positions inside the CTL register and the input filter depth.
package rp_8bit_pcint_pkg;

  localparam int REG_MSK = 0;
  localparam int REG_CTL = 1;
  localparam int REG_CAP = 2;

  localparam logic [2:0] SEL_MSK = 3'b001;
  localparam logic [2:0] SEL_CTL = 3'b010;
  localparam logic [2:0] SEL_CAP = 3'b100;

  localparam int PCIF_BIT = 0;
  localparam int PCIE_BIT = 1;

  // Number of consecutive equal samples the optional filter requires.
  localparam int FLT_LEN = 2;

endpackage

// File: rtl/rp_8bit_pcint_if.sv
// I/O peripheral bus for rp_8bit_pcint: one-hot read/write slot selects,
// 8-bit write data and combinational 8-bit read data.
//   io_re[2:0]  one-hot read select  (bit0 MSK, bit1 CTL, bit2 CAP)
//   io_we[2:0]  one-hot write select (same mapping)
//   io_dw[7:0]  write data
//   io_dr[7:0]  read data
// master drives selects and write data; slave returns read data.
interface rp_8bit_pcint_if;
  logic [2:0] io_re;
  logic [2:0] io_we;
  logic [7:0] io_dw;
  logic [7:0] io_dr;

  modport master (output io_re, output io_we, output io_dw, input io_dr);
  modport slave  (input io_re, input io_we, input io_dw, output io_dr);
endinterface

// File: rtl/rp_8bit_pcint_edge.sv
// Per-pin change detector for rp_8bit_pcint.
// Keeps the previous (optionally filtered) pin level and flags a change when
// the pin is enabled in the mask and the controller is primed after reset.
// Optional macro RP_8BIT_PCINT_FILTER_EN: the level must be seen for FLT_LEN
// consecutive samples before it is accepted, so short pulses are ignored.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   pin       synchronized pin level
//   msk       pin enable
//   primed    set once the controller has left reset long enough
//   chg       change event for this pin (combinational)
module rp_8bit_pcint_edge
  import rp_8bit_pcint_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic msk,
  input  logic primed,
  output logic chg
);

`ifdef RP_8BIT_PCINT_FILTER_EN
  localparam int SW = FLT_LEN - 1;

  logic [SW-1:0] smp_q;
  logic          pin_q;
  logic          stable;

  // The live pin plus the SW stored samples must all agree.
  assign stable = (smp_q == {SW{pin}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q <= '0;
      pin_q <= 1'b0;
    end else begin
      smp_q <= (smp_q << 1) | SW'(pin);
      if (stable) pin_q <= pin;
    end
  end

  // Change is reported in the cycle the new level is confirmed, so the
  // flag lands on the same edge that updates pin_q.
  assign chg = stable & (pin ^ pin_q) & msk & primed;
`else
  logic pin_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pin_q <= 1'b0;
    else     pin_q <= pin;
  end

  assign chg = (pin ^ pin_q) & msk & primed;
`endif

endmodule

// File: rtl/rp_8bit_pcint.sv
// rp_8bit_pcint: pin-change interrupt controller downstream of a GPIO port.
// Detects toggles on enabled pins, latches a pending flag (PCIF) and a per-pin
// capture vector, and drives a level interrupt request gated by PCIE.
// Optional macro RP_8BIT_PCINT_FILTER_EN adds a per-pin stability filter.
// Parameters: PDW monitored pin count (1..8), ADR informational base address.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       I/O register bus (slave): MSK, CTL {PCIE,PCIF}, CAP
//   pin       synchronized pin levels
//   irq_req   level interrupt request (pcif & pcie)
//   irq_ack   single-cycle acknowledge, clears pcif
module rp_8bit_pcint
  import rp_8bit_pcint_pkg::*;
#(
  parameter int         PDW = 8,
  parameter logic [5:0] ADR = 6'h00
)(
  input  logic                 clk,
  input  logic                 rst,
  rp_8bit_pcint_if.slave       bus,
  input  logic [PDW-1:0]       pin,
  output logic                 irq_req,
  input  logic                 irq_ack
);

  if (PDW < 1 || PDW > 8 || ADR > 6'h3F) begin : g_bad_cfg
    $error("rp_8bit_pcint: PDW must be 1..8");
  end

`ifdef RP_8BIT_PCINT_FILTER_EN
  localparam int PRIME_LEN = FLT_LEN;
`else
  localparam int PRIME_LEN = 1;
`endif
  localparam logic [1:0] PRIME_LAST = 2'(PRIME_LEN - 1);

  logic [PDW-1:0] msk;
  logic [PDW-1:0] cap;
  logic [PDW-1:0] chg;
  logic [PDW-1:0] cap_clr;
  logic           pcif;
  logic           pcie;
  logic           primed;
  logic [1:0]     prime_cnt;
  logic [7:0]     msk_rd;
  logic [7:0]     ctl_rd;
  logic [7:0]     cap_rd;

  for (genvar i = 0; i < PDW; i++) begin : g_edge
    rp_8bit_pcint_edge u_edge (
      .clk    (clk),
      .rst    (rst),
      .pin    (pin[i]),
      .msk    (msk[i]),
      .primed (primed),
      .chg    (chg[i])
    );
  end

  // Hold off detection until the pin history holds real post-reset samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_cnt <= '0;
      primed    <= 1'b0;
    end else if (!primed) begin
      if (prime_cnt == PRIME_LAST) primed <= 1'b1;
      prime_cnt <= prime_cnt + 2'd1;
    end
  end

  assign cap_clr = bus.io_we[REG_CAP] ? bus.io_dw[PDW-1:0] : '0;

  // New events win over acknowledge and write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msk  <= '0;
      pcie <= 1'b0;
      pcif <= 1'b0;
      cap  <= '0;
    end else begin
      if (bus.io_we[REG_MSK]) msk  <= bus.io_dw[PDW-1:0];
      if (bus.io_we[REG_CTL]) pcie <= bus.io_dw[PCIE_BIT];
      if (|chg)
        pcif <= 1'b1;
      else if (irq_ack || (bus.io_we[REG_CTL] && bus.io_dw[PCIF_BIT]))
        pcif <= 1'b0;
      cap <= (cap & ~cap_clr) | chg;
    end
  end

  assign irq_req = pcif & pcie;

  always_comb begin
    msk_rd = '0;
    msk_rd[PDW-1:0] = msk;
    cap_rd = '0;
    cap_rd[PDW-1:0] = cap;
    ctl_rd = '0;
    ctl_rd[PCIF_BIT] = pcif;
    ctl_rd[PCIE_BIT] = pcie;
    case (bus.io_re)
      SEL_MSK: bus.io_dr = msk_rd;
      SEL_CTL: bus.io_dr = ctl_rd;
      SEL_CAP: bus.io_dr = cap_rd;
      default: bus.io_dr = 'x;
    endcase
  end

endmodule
